// File: rtl/booth_vector_sequencer_if.sv
// Start/Done handshake and status bundle between booth_vector_sequencer (master)
// and the Booth multiplier plus run control (slave).
interface booth_vector_sequencer_if #(
  parameter int unsigned N           = 8,
  parameter int unsigned NUM_VECTORS = 8
);
  localparam int unsigned P  = 2 * N;
  localparam int unsigned IW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;

  logic          Go;
  logic          Done;
  logic [P-1:0]  Product;
  logic          Start;
  logic [N-1:0]  Mplier;
  logic [N-1:0]  Mcand;
  logic [IW-1:0] VecIdx;
  logic [P-1:0]  Captured;
  logic          CapValid;
  logic          Busy;
  logic          RunDone;
  logic          TimedOut;
  logic [7:0]    ErrCount;
  logic          PassAll;

  modport master (
    input  Go, Done, Product,
    output Start, Mplier, Mcand, VecIdx, Captured, CapValid,
           Busy, RunDone, TimedOut, ErrCount, PassAll
  );

  modport slave (
    output Go, Done, Product,
    input  Start, Mplier, Mcand, VecIdx, Captured, CapValid,
           Busy, RunDone, TimedOut, ErrCount, PassAll
  );
endinterface

// File: rtl/booth_vector_sequencer.sv
// ROM-driven initiator for the Booth multiplier Start/Done handshake; vector ROM word i
// ({Mplier,Mcand}) is VEC_INIT[i*2N +: 2N]. Define SEQ_SELFCHECK_EN for on-chip product checking.
module booth_vector_sequencer #(
  parameter int unsigned N            = 8,
  parameter int unsigned NUM_VECTORS  = 8,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 64,
  parameter logic [NUM_VECTORS*2*N-1:0] VEC_INIT = {
    16'hFFFF, 16'h7F80, 16'h01FF, 16'h8080,
    16'h0000, 16'h7F7F, 16'hFF80, 16'h0305
  }
) (
  input logic                      Clock,
  input logic                      Resetn,
  booth_vector_sequencer_if.master bus
);

  localparam int unsigned P    = 2 * N;
  localparam int unsigned IW   = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam int unsigned MAXC = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC) + 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_SETUP   = 3'd2;
  localparam logic [2:0] ST_START   = 3'd3;
  localparam logic [2:0] ST_WAIT_HI = 3'd4;
  localparam logic [2:0] ST_WAIT_LO = 3'd5;
  localparam logic [2:0] ST_CAPTURE = 3'd6;
  localparam logic [2:0] ST_FINISH  = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [IW-1:0] idx_d;
  logic [N-1:0]  mplier_d, mcand_d;
  logic [P-1:0]  captured_d;
  logic          cap_valid_d;
  logic [7:0]    err_d;
  logic          tout_d;
  logic          start_d, busy_d, run_done_d, pass_d;

  // Vector ROM unpacked from the flat parameter
  logic [P-1:0] rom [NUM_VECTORS];
  for (genvar g = 0; g < NUM_VECTORS; g++) begin : g_rom
    assign rom[g] = VEC_INIT[g*P +: P];
  end

`ifdef SEQ_SELFCHECK_EN
  // Reference product from the held operands; compared while Done is low
  logic signed [P-1:0] expected;
  logic                mismatch;
  assign expected = P'($signed(bus.Mplier)) * P'($signed(bus.Mcand));
  assign mismatch = (expected != $signed(bus.Product));
`endif

  // State and all registered outputs; reset clears everything at once
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bus.Start    <= 1'b0;
      bus.Mplier   <= '0;
      bus.Mcand    <= '0;
      bus.VecIdx   <= '0;
      bus.Captured <= '0;
      bus.CapValid <= 1'b0;
      bus.Busy     <= 1'b0;
      bus.RunDone  <= 1'b0;
      bus.TimedOut <= 1'b0;
      bus.ErrCount <= '0;
      bus.PassAll  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus.Start    <= start_d;
      bus.Mplier   <= mplier_d;
      bus.Mcand    <= mcand_d;
      bus.VecIdx   <= idx_d;
      bus.Captured <= captured_d;
      bus.CapValid <= cap_valid_d;
      bus.Busy     <= busy_d;
      bus.RunDone  <= run_done_d;
      bus.TimedOut <= tout_d;
      bus.ErrCount <= err_d;
      bus.PassAll  <= pass_d;
    end
  end

  // Next state and next output values; outputs are derived from the next state so they
  // line up with the state they describe
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = bus.VecIdx;
    mplier_d    = bus.Mplier;
    mcand_d     = bus.Mcand;
    captured_d  = bus.Captured;
    cap_valid_d = 1'b0;
    err_d       = bus.ErrCount;
    tout_d      = bus.TimedOut;

    case (state_q)
      ST_IDLE: begin
        if (bus.Go) begin
          idx_d   = '0;
          err_d   = '0;
          tout_d  = 1'b0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        {mplier_d, mcand_d} = rom[bus.VecIdx];
        state_d             = ST_SETUP;
      end

      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_START;
      end

      ST_START: begin
        if (cnt_q == CW'(START_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT_HI;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_WAIT_HI: begin
        if (bus.Done) begin
          cnt_d   = '0;
          state_d = ST_WAIT_LO;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          tout_d  = 1'b1;
          state_d = ST_FINISH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Product is sampled on the first Done-low cycle and lands in Captured with CapValid
      ST_WAIT_LO: begin
        if (!bus.Done) begin
          captured_d  = bus.Product;
          cap_valid_d = 1'b1;
`ifdef SEQ_SELFCHECK_EN
          if (mismatch && (bus.ErrCount != 8'hFF)) begin
            err_d = bus.ErrCount + 8'd1;
          end
`endif
          state_d = ST_CAPTURE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          tout_d  = 1'b1;
          state_d = ST_FINISH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_CAPTURE: begin
        if (bus.VecIdx == IW'(NUM_VECTORS - 1)) begin
          state_d = ST_FINISH;
        end else begin
          idx_d   = bus.VecIdx + IW'(1);
          state_d = ST_LOAD;
        end
      end

      ST_FINISH: begin
        if (!bus.Go) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    start_d    = (state_d == ST_START);
    busy_d     = (state_d != ST_IDLE) && (state_d != ST_FINISH);
    run_done_d = (state_d == ST_FINISH);
`ifdef SEQ_SELFCHECK_EN
    pass_d     = run_done_d && !tout_d && (err_d == 8'd0);
`else
    pass_d     = run_done_d && !tout_d;
`endif
  end

endmodule

// File: tb/tb_booth_vector_sequencer.sv
// Directed bench for booth_vector_sequencer with a behavioural radix-2 Booth responder.
// Expectations follow SEQ_SELFCHECK_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_booth_vector_sequencer;

  localparam int unsigned N  = 8;
  localparam int unsigned NV = 8;
  localparam int unsigned P  = 16;
  localparam logic [NV*P-1:0] VECS = {
    16'hFFFF, 16'h7F80, 16'h01FF, 16'h8080,
    16'h0000, 16'h7F7F, 16'hFF80, 16'h0305
  };

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_vector_sequencer_if #(.N(N), .NUM_VECTORS(NV)) bus ();

  booth_vector_sequencer #(
    .N(N), .NUM_VECTORS(NV), .START_CYCLES(2), .TIMEOUT(64), .VEC_INIT(VECS)
  ) dut (
    .Clock (clk),
    .Resetn(rst_n),
    .bus   (bus)
  );

  // Hand-computed products of the vectors above, in ROM order
  logic [15:0] exp_prod [8] = '{16'h000F, 16'h0080, 16'h3F01, 16'h0000,
                                16'h4000, 16'hFFFF, 16'hC080, 16'h0001};

  int n_cmp = 0;
  int n_mis = 0;
  int cap_count = 0;

  int resp_lat    = 1;
  int resp_dlen   = 1;
  int corrupt_idx = -1;
  logic no_done   = 1'b0;

  function automatic logic [15:0] booth_mul(input logic [7:0] mplier, input logic [7:0] mcand);
    logic [8:0]  a;
    logic [8:0]  m9;
    logic [7:0]  q;
    logic        q1;
    logic [17:0] s;
    a  = '0;
    q  = mplier;
    q1 = 1'b0;
    m9 = {mcand[7], mcand};
    for (int i = 0; i < 8; i++) begin
      case ({q[0], q1})
        2'b01:   a = a + m9;
        2'b10:   a = a - m9;
        default: ;
      endcase
      s = {a, q, q1};
      s = {s[17], s[17:1]};
      {a, q, q1} = s;
    end
    return {a[7:0], q};
  endfunction

  // Responder: after Start, wait resp_lat edges, raise Done for resp_dlen cycles
  logic armed, active;
  int   rcnt, dcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Done    <= 1'b0;
      bus.Product <= '0;
      armed       <= 1'b1;
      active      <= 1'b0;
      rcnt        <= 0;
      dcnt        <= 0;
    end else begin
      if (!bus.Start) armed <= 1'b1;
      if (!active) begin
        if (bus.Start && armed && !no_done) begin
          armed  <= 1'b0;
          active <= 1'b1;
          rcnt   <= resp_lat;
        end
      end else if (!bus.Done) begin
        if (rcnt <= 1) begin
          bus.Done    <= 1'b1;
          dcnt        <= resp_dlen;
          bus.Product <= (int'(bus.VecIdx) == corrupt_idx) ? 16'hDEAD
                                                           : booth_mul(bus.Mplier, bus.Mcand);
        end else begin
          rcnt <= rcnt - 1;
        end
      end else begin
        if (dcnt <= 1) begin
          bus.Done <= 1'b0;
          active   <= 1'b0;
        end else begin
          dcnt <= dcnt - 1;
        end
      end
    end
  end

  always @(negedge clk) if (bus.CapValid === 1'b1) cap_count++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Wait (bounded) for the CapValid of vector k and check its payload
  task automatic wait_cap(input int k, input logic [15:0] exp_cap);
    int c;
    c = 0;
    while (bus.CapValid !== 1'b1 && c < 300) begin
      tick();
      c++;
    end
    chk($sformatf("capvalid_v%0d", k), 32'(bus.CapValid), 32'd1);
    chk($sformatf("vecidx_v%0d", k), 32'(bus.VecIdx), 32'(k));
    chk($sformatf("captured_v%0d", k), 32'(bus.Captured), 32'(exp_cap));
    tick();
  endtask

  task automatic run_from(input int first, input int corrupt);
    for (int k = first; k < int'(NV); k++) begin
      wait_cap(k, (k == corrupt) ? 16'hDEAD : exp_prod[k]);
    end
  endtask

  task automatic pulse_go();
    bus.Go = 1'b1;
    tick();
    bus.Go = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    bus.Go = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_start",    32'(bus.Start),    32'd0);
    chk("rst_busy",     32'(bus.Busy),     32'd0);
    chk("rst_rundone",  32'(bus.RunDone),  32'd0);
    chk("rst_capvalid", 32'(bus.CapValid), 32'd0);
    chk("rst_captured", 32'(bus.Captured), 32'd0);
    chk("rst_errcount", 32'(bus.ErrCount), 32'd0);
    chk("rst_passall",  32'(bus.PassAll),  32'd0);
    chk("rst_timedout", 32'(bus.TimedOut), 32'd0);
    chk("rst_ops",      32'({bus.Mplier, bus.Mcand, bus.VecIdx}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Full run; Done arrives already high on WAIT_HI entry
    resp_lat  = 1;
    resp_dlen = 1;
    base      = cap_count;
    pulse_go();
    chk("t1_load_busy",  32'(bus.Busy),  32'd1);
    chk("t1_load_start", 32'(bus.Start), 32'd0);
    tick();
    chk("t1_setup_ops",   32'({bus.Mplier, bus.Mcand}), 32'h0305);
    chk("t1_setup_start", 32'(bus.Start), 32'd0);
    tick();
    chk("t1_start_c0", 32'(bus.Start), 32'd1);
    tick();
    chk("t1_start_c1", 32'(bus.Start), 32'd1);
    tick();
    chk("t1_start_off", 32'(bus.Start), 32'd0);
    run_from(0, -1);
    chk("t1_rundone", 32'(bus.RunDone), 32'd1);
    chk("t1_passall", 32'(bus.PassAll), 32'd1);
    chk("t1_busy",    32'(bus.Busy),    32'd0);
    chk("t1_capcnt",  32'(cap_count - base), 32'd8);

    // Corrupted product on vector 2, slower responder
    tick();
    resp_lat    = 4;
    resp_dlen   = 2;
    corrupt_idx = 2;
    pulse_go();
    run_from(0, 2);
    chk("t3_rundone", 32'(bus.RunDone), 32'd1);
`ifdef SEQ_SELFCHECK_EN
    chk("t3_errcount", 32'(bus.ErrCount), 32'd1);
    chk("t3_passall",  32'(bus.PassAll),  32'd0);
`else
    chk("t3_errcount", 32'(bus.ErrCount), 32'd0);
    chk("t3_passall",  32'(bus.PassAll),  32'd1);
`endif
    corrupt_idx = -1;

    // Responder never raises Done; Go held high throughout
    tick();
    no_done = 1'b1;
    base    = cap_count;
    bus.Go  = 1'b1;
    n = 0;
    while (bus.Start !== 1'b1 && n < 20) begin tick(); n++; end
    chk("t4_start_seen", 32'(bus.Start), 32'd1);
    n = 0;
    while (bus.Start === 1'b1 && n < 20) begin tick(); n++; end
    n = 0;
    while (bus.RunDone !== 1'b1 && n < 200) begin tick(); n++; end
    chk("t4_wait_cycles", 32'(n),            32'd64);
    chk("t4_timedout",    32'(bus.TimedOut), 32'd1);
    chk("t4_rundone",     32'(bus.RunDone),  32'd1);
    chk("t4_start",       32'(bus.Start),    32'd0);
    chk("t4_passall",     32'(bus.PassAll),  32'd0);
    chk("t4_vecidx",      32'(bus.VecIdx),   32'd0);
    chk("t4_capcnt",      32'(cap_count - base), 32'd0);

    // Go held through FINISH: no restart
    repeat (10) tick();
    chk("t6_hold_rundone", 32'(bus.RunDone), 32'd1);
    chk("t6_hold_busy",    32'(bus.Busy),    32'd0);
    chk("t6_hold_capcnt",  32'(cap_count - base), 32'd0);
    bus.Go = 1'b0;
    tick();
    chk("t6_idle_rundone", 32'(bus.RunDone), 32'd0);

    // Second full run clears TimedOut and ErrCount
    no_done   = 1'b0;
    resp_lat  = 2;
    resp_dlen = 3;
    base      = cap_count;
    pulse_go();
    chk("t6_timedout_clr", 32'(bus.TimedOut), 32'd0);
    chk("t6_errcount_clr", 32'(bus.ErrCount), 32'd0);
    chk("t6_busy",         32'(bus.Busy),     32'd1);
    run_from(0, -1);
    chk("t6_rundone", 32'(bus.RunDone),  32'd1);
    chk("t6_passall", 32'(bus.PassAll),  32'd1);
    chk("t6_capcnt",  32'(cap_count - base), 32'd8);

    // Asynchronous reset while in WAIT_LO of vector 3
    tick();
    resp_lat  = 1;
    resp_dlen = 10;
    pulse_go();
    n = 0;
    while (!(bus.VecIdx === 3'd3 && bus.Done === 1'b1) && n < 500) begin tick(); n++; end
    chk("t5_reached_v3", 32'({bus.VecIdx, bus.Done}), 32'({3'd3, 1'b1}));
    repeat (2) tick();
    chk("t5_pre_busy",     32'(bus.Busy),     32'd1);
    chk("t5_pre_captured", 32'(bus.Captured), 32'h3F01);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_start",    32'(bus.Start),    32'd0);
    chk("t5_rst_busy",     32'(bus.Busy),     32'd0);
    chk("t5_rst_captured", 32'(bus.Captured), 32'd0);
    chk("t5_rst_vecidx",   32'(bus.VecIdx),   32'd0);
    tick();
    rst_n     = 1'b1;
    resp_dlen = 1;
    tick();
    pulse_go();
    run_from(0, -1);
    chk("t5_rundone", 32'(bus.RunDone), 32'd1);
    chk("t5_passall", 32'(bus.PassAll), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
